gmii_frame_gen: RTL

Synthesizable, parametrised GMII transmit-side stimulus generator for the PCS test bench; next generation of the fixed-pattern TX tester. Emits whole frames (preamble, SFD, payload, IPG) on TXD/TX_EN/TX_ER, gated by xmit. Supports frame bursts, configurable lengths and single-byte error injection. Drives the PCS TX under test directly, clocked by GTX_CLK.

---
 rtl/pcs_tb_pkg.sv | 35 +++
 rtl/gmii_frame_gen_if.sv | 35 +++
 rtl/gmii_payload_src.sv | 48 ++++
 rtl/gmii_frame_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_tb_pkg.sv
// Shared constants and encodings for the GMII TX frame generator.
// Optional PRBS payload is selected with GMII_GEN_PRBS_EN.
package pcs_tb_pkg;

    localparam logic [2:0] XMIT_CONFIG = 3'b100;
    localparam logic [2:0] XMIT_IDLE   = 3'b010;
    localparam logic [2:0] XMIT_DATA   = 3'b001;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] ERR_BYTE      = 8'hFF;

    // Taps of x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [7:0] PRBS_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_ABORT,
        ST_IPG
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        if (w < 4) w = 4;
        if (w > 8) w = 8;
        return w;
    endfunction

endpackage

// File: rtl/gmii_frame_gen_if.sv
// Control and GMII signal bundle of the frame generator.
// master = stimulus/controller side, slave = generator side.
interface gmii_frame_gen_if #(
    parameter int LEN_W = 11,
    parameter int CNT_W = 16
);
    logic [2:0]       xmit;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       num_frames;
    logic [7:0]       seed;
    logic             err_inject;
    logic [LEN_W-1:0] err_pos;
    logic [7:0]       TXD;
    logic             TX_EN;
    logic             TX_ER;
    logic             busy;
    logic             done;
    logic             reject;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output xmit, start, frame_len, num_frames,
        output seed, err_inject, err_pos,
        input  TXD, TX_EN, TX_ER,
        input  busy, done, reject, frame_count
    );

    modport slave (
        input  xmit, start, frame_len, num_frames,
        input  seed, err_inject, err_pos,
        output TXD, TX_EN, TX_ER,
        output busy, done, reject, frame_count
    );
endinterface

// File: rtl/gmii_payload_src.sv
// Payload byte source: incrementing counter, or LFSR with GMII_GEN_PRBS_EN.
// o_byte is the next byte to emit; i_advance steps it after use.
module gmii_payload_src
    import pcs_tb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_advance,
    output logic [7:0] o_byte
);

`ifdef GMII_GEN_PRBS_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = ^(r_lfsr & PRBS_TAPS);

    // An all-zero seed would lock the LFSR, so it is replaced by 0xFF
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= 8'hFF;
        end else if (i_load) begin
            r_lfsr <= (i_seed == 8'h00) ? 8'hFF : i_seed;
        end else if (i_advance) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_byte = r_lfsr;
`else
    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 8'h00;
        end else if (i_load) begin
            r_cnt <= i_seed;
        end else if (i_advance) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_byte = r_cnt;
`endif

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII transmit frame generator: preamble, SFD, payload, IPG bursts.
// Payload source depends on GMII_GEN_PRBS_EN (see gmii_payload_src).
module gmii_frame_gen
    import pcs_tb_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12,
    parameter int LEN_W        = 11,
    parameter int CNT_W        = 16
) (
    input  logic GTX_CLK,
    input  logic mr_main_reset,
    gmii_frame_gen_if.slave bus
);

    localparam int CW = cnt_width(PREAMBLE_LEN, IPG_LEN);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN);
    localparam logic [CW-1:0] IPG_LAST = CW'(IPG_LEN);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [LEN_W-1:0] r_byte;
    logic [7:0]       r_left;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_seed;
    logic             r_err_en;
    logic [LEN_W-1:0] r_err_pos;
    logic [CNT_W-1:0] r_fc;
    logic [7:0]       r_txd;
    logic             r_en;
    logic             r_er;
    logic             r_busy;
    logic             r_done;
    logic             r_rej;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [LEN_W-1:0] w_byte_nxt;
    logic [7:0]       w_left_nxt;
    logic [CNT_W-1:0] w_fc_nxt;
    logic [7:0]       w_txd_nxt;
    logic             w_en_nxt;
    logic             w_er_nxt;
    logic             w_done_nxt;
    logic             w_rej_nxt;
    logic             w_latch;
    logic             w_pl_load;
    logic             w_pl_adv;
    logic             w_data;
    logic [7:0]       w_pl_byte;

    assign w_data = (bus.xmit == XMIT_DATA);

    gmii_payload_src u_payload (
        .i_clk     (GTX_CLK),
        .i_rst     (mr_main_reset),
        .i_load    (w_pl_load),
        .i_seed    (r_seed),
        .i_advance (w_pl_adv),
        .o_byte    (w_pl_byte)
    );

    // Outputs are decoded for the state being entered, then registered,
    // so r_state always names the byte currently on TXD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_byte_nxt  = r_byte;
        w_left_nxt  = r_left;
        w_fc_nxt    = r_fc;
        w_txd_nxt   = 8'h00;
        w_en_nxt    = 1'b0;
        w_er_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_rej_nxt   = 1'b0;
        w_latch     = 1'b0;
        w_pl_load   = 1'b0;
        w_pl_adv    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_data && (bus.frame_len != '0)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_PRE;
                        w_cnt_nxt   = CW'(1);
                        w_left_nxt  = (bus.num_frames == 8'd0) ?
                                      8'd1 : bus.num_frames;
                        w_txd_nxt   = PREAMBLE_BYTE;
                        w_en_nxt    = 1'b1;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end
            end

            ST_PRE: begin
                if (!w_data) begin
                    w_state_nxt = ST_ABORT;
                end else if (r_cnt == PRE_LAST) begin
                    w_state_nxt = ST_SFD;
                    w_pl_load   = 1'b1;
                    w_txd_nxt   = SFD_BYTE;
                    w_en_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_txd_nxt = PREAMBLE_BYTE;
                    w_en_nxt  = 1'b1;
                end
            end

            ST_SFD: begin
                if (!w_data) begin
                    w_state_nxt = ST_ABORT;
                end else begin
                    w_state_nxt = ST_DATA;
                    w_byte_nxt  = '0;
                    w_pl_adv    = 1'b1;
                    w_txd_nxt   = w_pl_byte;
                    w_en_nxt    = 1'b1;
                    w_er_nxt    = r_err_en && (r_err_pos == '0);
                end
            end

            ST_DATA: begin
                if (!w_data) begin
                    w_state_nxt = ST_ABORT;
                end else if (r_byte == r_len - 1'b1) begin
                    w_state_nxt = ST_IPG;
                    w_cnt_nxt   = CW'(1);
                    w_left_nxt  = r_left - 8'd1;
                    w_fc_nxt    = r_fc + 1'b1;
                end else begin
                    w_byte_nxt = r_byte + 1'b1;
                    w_pl_adv   = 1'b1;
                    w_txd_nxt  = w_pl_byte;
                    w_en_nxt   = 1'b1;
                    w_er_nxt   = r_err_en && (w_byte_nxt == r_err_pos);
                end
            end

            ST_ABORT: begin
                w_state_nxt = ST_IPG;
                w_cnt_nxt   = CW'(1);
                w_left_nxt  = 8'd0;
            end

            ST_IPG: begin
                if (!w_data) begin
                    w_left_nxt = 8'd0;
                end
                if (r_cnt == IPG_LAST) begin
                    if ((r_left != 8'd0) && w_data) begin
                        w_state_nxt = ST_PRE;
                        w_cnt_nxt   = CW'(1);
                        w_txd_nxt   = PREAMBLE_BYTE;
                        w_en_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_ABORT) begin
            w_txd_nxt = ERR_BYTE;
            w_en_nxt  = 1'b1;
            w_er_nxt  = 1'b1;
        end
    end

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_byte    <= '0;
            r_left    <= 8'd0;
            r_fc      <= '0;
            r_txd     <= 8'h00;
            r_en      <= 1'b0;
            r_er      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rej     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_byte    <= w_byte_nxt;
            r_left    <= w_left_nxt;
            r_fc      <= w_fc_nxt;
            r_txd     <= w_txd_nxt;
            r_en      <= w_en_nxt;
            r_er      <= w_er_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
            r_rej     <= w_rej_nxt;
        end
    end

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            r_len     <= '0;
            r_seed    <= 8'h00;
            r_err_en  <= 1'b0;
            r_err_pos <= '0;
        end else if (w_latch) begin
            r_len     <= bus.frame_len;
            r_seed    <= bus.seed;
            r_err_en  <= bus.err_inject;
            r_err_pos <= bus.err_pos;
        end
    end

    assign bus.TXD         = r_txd;
    assign bus.TX_EN       = r_en;
    assign bus.TX_ER       = r_er;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.reject      = r_rej;
    assign bus.frame_count = r_fc;

endmodule
